tt_um_ethansam9_uart_tx: RTL



---
 rtl/tt_uart_pkg.sv | 18 +
 rtl/tt_uart_baud_tick.sv | 41 ++++
 rtl/tt_um_ethansam9_uart_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the Tiny Tapeout UART transmitter.
// The PARITY state is only reachable when TT_UART_PARITY_EN is defined.
package tt_uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned IDX_W          = $clog2(DATA_BITS);
    localparam int unsigned FRAME_BITS_8N1 = 10;
    localparam int unsigned FRAME_BITS_8E1 = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/tt_uart_baud_tick.sv
// Bit-period timer: registered tick on the last cycle of each bit period,
// pre_tick one cycle earlier. Held at zero while not running or when cleared.
module tt_uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next count; flags below are registered from it so they line up with cnt.
    always_comb begin
        cnt_nxt = '0;
        if (!clr && run) begin
            if (cnt != CNT_W'(CLKS_PER_BIT - 1)) begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            tick     <= 1'b0;
            pre_tick <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            tick     <= (cnt_nxt == CNT_W'(CLKS_PER_BIT - 1));
            pre_tick <= (cnt_nxt == CNT_W'(CLKS_PER_BIT - 2));
        end
    end

endmodule

// File: rtl/tt_um_ethansam9_uart_tx.sv
// Tiny Tapeout UART transmitter: one byte from ui_in as an 8N1 frame on uo_out[0].
// Define TT_UART_PARITY_EN for an 8E1 frame (even parity bit before stop).
module tt_um_ethansam9_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    uart_tx_state_t         state;
    logic [DATA_BITS-1:0]   shreg;
    logic [IDX_W-1:0]       bit_idx;
    logic                   tx;
    logic                   busy;
    logic                   done;
    logic                   start_prev;
    logic                   tick;
    logic                   pre_tick;
    logic                   start_ok_c;
`ifdef TT_UART_PARITY_EN
    logic                   parity_bit;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:1]};

    assign start_ok_c = (state == ST_IDLE) && ena && uio_in[0] && !start_prev;

    tt_uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok_c),
        .run      (state != ST_IDLE),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // Frame sequencer; tx/busy/done are registered and change on bit boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_prev <= 1'b0;
`ifdef TT_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            start_prev <= uio_in[0];
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        shreg   <= ui_in;
                        bit_idx <= '0;
                        state   <= ST_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
`ifdef TT_UART_PARITY_EN
                        parity_bit <= ^ui_in;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef TT_UART_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity_bit;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef TT_UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    done <= pre_tick;
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = {5'b0, done, busy, tx};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
